wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter.
- Master 0 is the CPU data port; master 1 is the UART debug bridge (uart2wb).
- Shares the single 8-bit system bus (RAM/peripheral decoder) between them with round-robin fairness, so the PC-side debugger can peek and poke memory while the CPU runs.
- Sits between both masters and the address decoder, in the top level.

Parameters:
- ADDR_W, 24, address width of all master and slave address ports
- DATA_W, 8, data width of all data ports
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before bus error (used only with the optional feature)

Ports:
- i_wb_clk  in  1  system clock, all logic on rising edge
- i_wb_rst_n  in  1  asynchronous active-low reset
- i_mN_cyc (N=0,1)  in  1  master N bus request; held for the whole transaction/burst
- i_mN_stb (N=0,1)  in  1  master N strobe
- i_mN_we (N=0,1)  in  1  master N write enable
- i_mN_adr (N=0,1)  in  ADDR_W  master N address
- i_mN_dat (N=0,1)  in  DATA_W  master N write data
- o_mN_dat (N=0,1)  out  DATA_W  read data to master N
- o_mN_ack (N=0,1)  out  1  ack to master N
- o_mN_err (N=0,1)  out  1  bus error to master N
- o_s_cyc  out  1  slave cyc
- o_s_stb  out  1  slave stb
- o_s_we  out  1  slave we
- o_s_adr  out  ADDR_W  slave address
- o_s_dat  out  DATA_W  slave write data
- i_s_dat  in  DATA_W  slave read data
- i_s_ack  in  1  slave ack
- o_grant  out  2  one-hot current owner; 2'b00 when idle

Behaviour:
- States: IDLE, GRANT0, GRANT1. Registers: state, last_owner (1 bit).
- Reset (async, i_wb_rst_n=0):
  - state=IDLE, last_owner=1, so master 0 wins the first tie.
  - All outputs 0 while in reset.
- IDLE:
  - Only i_m0_cyc → GRANT0. Only i_m1_cyc → GRANT1.
  - Both asserted → grant the master != last_owner.
  - Neither asserted → stay in IDLE.
  - On entering GRANTn, set last_owner=n.
  - Arbitration latency is one cycle: a request sampled in IDLE sees a registered grant on the next edge.
- GRANTn:
  - o_s_cyc/stb/we/adr/dat are combinationally muxed from master n.
  - o_mn_dat=i_s_dat and o_mn_ack=i_s_ack, combinational.
  - The other master sees ack=0, err=0, dat=0; its stb is ignored.
- Release: when i_mn_cyc=0 is sampled in GRANTn, go to IDLE.
  - There is exactly one dead cycle between owners; o_s_cyc=0 in that cycle.
- Lock: the owner keeps the bus for as long as cyc stays high. Multi-beat accesses are never split.
- o_grant = {state==GRANT1, state==GRANT0}.
- IDLE outputs: o_s_* all 0, all o_mN_ack=0.
- Simultaneous events:
  - cyc dropping in the same cycle as i_s_ack: the ack is still passed through to the owner, and the state goes to IDLE.
  - i_s_ack while IDLE is ignored and not forwarded.
- Without the optional feature, o_mN_err is tied to 0.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - The counter clears on reset, in IDLE, on i_s_ack, and when o_s_stb=0.
  - It increments each GRANTn cycle with o_s_stb=1 and i_s_ack=0.
  - When it reaches TIMEOUT_CYCLES: o_mn_err=1 for one cycle, the state is forced to IDLE, and the counter clears. The owner must then drop cyc.
  - If the owner's cyc is still high, it is re-arbitrated normally.
- When undefined: no counter, o_mN_err=0, and a hung slave holds the bus indefinitely.

Decomposition:
- Shared package wb_pkg:
  - state encoding localparams ARB_IDLE=2'd0, ARB_G0=2'd1, ARB_G1=2'd2
  - default ADDR_W/DATA_W constants
- One natural sub-module: wb_arb_timeout (counter plus expiry pulse), instantiated only under WB_ARB_TIMEOUT_EN.
- Mux and FSM stay in wb_arbiter2.

Test Plan:
- Reset, then only m1 requests: read adr 0x000123, slave returns 0xA5 → o_grant=2'b10 one cycle after cyc; o_m1_dat=0xA5 with o_m1_ack; m0 sees ack=0.
- m0 and m1 raise cyc in the same cycle after reset → m0 granted first (o_grant=01). m0 drops cyc → one IDLE cycle (o_s_cyc=0), then o_grant=10.
- Both masters continuously request 4 single-beat transactions each → grants strictly alternate 01,10,01,10…; no master gets two consecutive grants while the other waits.
- m1 holds cyc for a 3-beat write 0x11,0x22,0x33 while m0 requests → m0 is not granted until m1 drops cyc; the slave sees all three writes in order.
- i_wb_rst_n pulsed low mid-transaction (GRANT0, stb=1) → all outputs 0 immediately; after release, the next tie goes to m0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks m0 → o_m0_err=1 exactly 8 cycles after stb, state returns to IDLE, m1 is then grantable.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg: shared definitions for the Wishbone arbiter slice.
//   - Arbiter state encoding (IDLE / GRANT0 / GRANT1)
//   - Default bus widths used by the system bus
// ---------------------------------------------------------------------------
package wb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_G0   = 2'd1;
  localparam arb_state_t ARB_G1   = 2'd2;

  localparam int WB_ADDR_W = 24;
  localparam int WB_DATA_W = 8;

endpackage

// File: rtl/wb_arb_timeout.sv
// ---------------------------------------------------------------------------
// wb_arb_timeout: stb-without-ack watchdog for the arbiter.
// Counts cycles in which the granted master strobes and the slave does not
// ack. When the count reaches TIMEOUT_CYCLES, expire_o pulses for one cycle
// and the counter restarts from zero.
// Ports:
//   clk_i, rst_ni  clock / asynchronous active-low reset
//   granted_i      arbiter is in a GRANT state
//   stb_i          slave-side strobe (muxed from the owner)
//   ack_i          slave ack
//   expire_o       one-cycle timeout pulse
// ---------------------------------------------------------------------------
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic granted_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is decoded from the registered count, so it lands one cycle
  // after the TIMEOUT_CYCLES-th unacknowledged strobe cycle.
  assign expire_o = granted_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (!granted_i || !stb_i || ack_i || expire_o) cnt_d = '0;
    else                                           cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2: two-master / one-slave Wishbone arbiter, round-robin.
//   Master 0 = CPU data port, master 1 = UART debug bridge.
//   The owner keeps the bus while its cyc stays high; exactly one idle
//   cycle separates two owners. Arbitration is registered (one cycle).
// Ports:
//   i_wb_clk, i_wb_rst_n      clock / asynchronous active-low reset
//   i_mN_* / o_mN_*           master N request and response (N = 0,1)
//   o_s_* / i_s_*             shared slave side
//   o_grant                   one-hot owner, 2'b00 when idle
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stb-without-ack
// watchdog that returns o_mN_err and frees the bus after TIMEOUT_CYCLES.
// Without it, o_mN_err is tied low and a hung slave holds the bus.
// ---------------------------------------------------------------------------
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int          ADDR_W         = WB_ADDR_W,
  parameter int          DATA_W         = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  // master 0
  input  logic              i_m0_cyc,
  input  logic              i_m0_stb,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_adr,
  input  logic [DATA_W-1:0] i_m0_dat,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  // master 1
  input  logic              i_m1_cyc,
  input  logic              i_m1_stb,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_adr,
  input  logic [DATA_W-1:0] i_m1_dat,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  // slave
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [ADDR_W-1:0] o_s_adr,
  output logic [DATA_W-1:0] o_s_dat,
  input  logic [DATA_W-1:0] i_s_dat,
  input  logic              i_s_ack,
  output logic [1:0]        o_grant
);

  arb_state_t state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       to_expire;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (i_wb_clk),
    .rst_ni    (i_wb_rst_n),
    .granted_i (state_q != ARB_IDLE),
    .stb_i     (o_s_stb),
    .ack_i     (i_s_ack),
    .expire_o  (to_expire)
  );
`else
  assign to_expire = 1'b0;
  // Watchdog length has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register. last_owner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next state: round-robin on ties, release on cyc low or watchdog expiry.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_owner_q)) begin
          state_d      = ARB_G0;
          last_owner_d = 1'b0;
        end else if (i_m1_cyc) begin
          state_d      = ARB_G1;
          last_owner_d = 1'b1;
        end
      end
      ARB_G0:  if (!i_m0_cyc || to_expire) state_d = ARB_IDLE;
      ARB_G1:  if (!i_m1_cyc || to_expire) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: pure mux from the owner; everything idles at zero, so slave
  // acks seen while IDLE never reach a master.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    o_grant  = 2'b00;
    case (state_q)
      ARB_G0: begin
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb;
        o_s_we   = i_m0_we;
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = to_expire;
        o_grant  = 2'b01;
      end
      ARB_G1: begin
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb;
        o_s_we   = i_m1_we;
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = to_expire;
        o_grant  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
  localparam int AW = 24;
  localparam int DW = 8;

  typedef struct packed {
    logic          err;
    logic          chk;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    m_cyc, m_stb, m_we, m_ack, m_err;
  logic [AW-1:0] m_adr  [2];
  logic [DW-1:0] m_wdat [2];
  logic [DW-1:0] m_rdat [2];

  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [1:0]    grant;

  wb_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
    .i_m0_adr(m_adr[0]), .i_m0_dat(m_wdat[0]),
    .o_m0_dat(m_rdat[0]), .o_m0_ack(m_ack[0]), .o_m0_err(m_err[0]),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
    .i_m1_adr(m_adr[1]), .i_m1_dat(m_wdat[1]),
    .o_m1_dat(m_rdat[1]), .o_m1_ack(m_ack[1]), .o_m1_err(m_err[1]),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_dat(s_wdat), .i_s_dat(s_rdat), .i_s_ack(s_ack), .o_grant(grant)
  );

  // Slave model: acks one cycle after strobe, read data = 0x11 * adr[3:0]
  // except index 3 which holds 0xA5.
  logic ack_q;
  logic hang = 1'b0;
  assign s_ack  = ack_q;
  assign s_rdat = (s_adr[3:0] == 4'h3) ? 8'hA5 : {s_adr[3:0], s_adr[3:0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= s_cyc && s_stb && !ack_q && !hang;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard queues
  exp_t q0[$];
  exp_t q1[$];
  wr_t  swq[$];
  exp_t e0, e1;
  wr_t  ew;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_ack[0] || m_err[0]) begin
        if (q0.size() == 0) chk("m0_unexpected_resp", 32'(1), 32'(0));
        else begin
          e0 = q0.pop_front();
          chk("m0_err", 32'(m_err[0]), 32'(e0.err));
          chk("m0_ack", 32'(m_ack[0]), 32'(!e0.err));
          if (e0.chk) chk("m0_rdat", 32'(m_rdat[0]), 32'(e0.dat));
        end
      end
      if (m_ack[1] || m_err[1]) begin
        if (q1.size() == 0) chk("m1_unexpected_resp", 32'(1), 32'(0));
        else begin
          e1 = q1.pop_front();
          chk("m1_err", 32'(m_err[1]), 32'(e1.err));
          chk("m1_ack", 32'(m_ack[1]), 32'(!e1.err));
          if (e1.chk) chk("m1_rdat", 32'(m_rdat[1]), 32'(e1.dat));
        end
      end
      if (s_cyc && s_stb && s_we && s_ack) begin
        if (swq.size() == 0) chk("slave_unexpected_write", 32'(1), 32'(0));
        else begin
          ew = swq.pop_front();
          chk("slave_wr_adr", 32'(s_adr), 32'(ew.adr));
          chk("slave_wr_dat", 32'(s_wdat), 32'(ew.dat));
        end
      end
    end
  end

  // Grant log: records each new owner as it appears after an idle cycle.
  logic [1:0] prev_g = 2'b00;
  logic [1:0] glog[$];
  always @(negedge clk) begin
    if (grant != 2'b00 && prev_g == 2'b00) glog.push_back(grant);
    prev_g <= grant;
  end

  task automatic issue(input int m, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [DW-1:0] exp_rd);
    exp_t e;
    wr_t  w;
    e.err = 1'b0; e.chk = !we; e.dat = exp_rd;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    if (we) begin
      w.adr = adr; w.dat = dat;
      swq.push_back(w);
    end
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_wdat[m] = dat;
  endtask

  task automatic drop(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  // Waits (bounded) for ack/err on master m; checks the other master is quiet.
  task automatic wait_ack(input int m);
    logic got = 1'b0;
    int   o   = 1 - m;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (m_ack[m] || m_err[m]) got = 1'b1;
    end
    chk($sformatf("m%0d_resp_seen", m), 32'(got), 32'(1));
    if (got) begin
      chk($sformatf("m%0d_ack_quiet", o), 32'(m_ack[o]), 32'(0));
      chk($sformatf("m%0d_dat_quiet", o), 32'(m_rdat[o]), 32'(0));
    end
  endtask

  task automatic rd_single(input int m, input logic [AW-1:0] adr, input logic [DW-1:0] exp_rd);
    issue(m, 1'b0, adr, '0, exp_rd);
    wait_ack(m);
    @(posedge clk); #1;
    drop(m);
  endtask

  task automatic run_m(input int m, input int base);
    for (int i = 0; i < 4; i++) begin
      rd_single(m, AW'(base + i), DW'(8'h11 * (base + i)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin m_adr[i] = '0; m_wdat[i] = '0; end

    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_s_cyc", 32'(s_cyc), 32'(0));
    chk("rst_acks", 32'({m_ack, m_err}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: lone m1 read
    @(posedge clk); #1;
    issue(1, 1'b0, 24'h000123, '0, 8'hA5);
    @(negedge clk);
    chk("t1_grant_idle", 32'(grant), 32'(2'b00));
    @(negedge clk);
    chk("t1_grant_m1", 32'(grant), 32'(2'b10));
    chk("t1_s_adr", 32'(s_adr), 32'(24'h000123));
    wait_ack(1);
    @(posedge clk); #1;
    drop(1);
    repeat (2) @(posedge clk); #1;

    // 2: tie after reset -> m0 first, one dead cycle, then m1
    issue(0, 1'b0, 24'h5, '0, 8'h55);
    issue(1, 1'b0, 24'h6, '0, 8'h66);
    @(negedge clk);
    @(negedge clk);
    chk("t2_grant_m0", 32'(grant), 32'(2'b01));
    wait_ack(0);
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_dead_grant", 32'(grant), 32'(2'b00));
    chk("t2_dead_s_cyc", 32'(s_cyc), 32'(0));
    @(negedge clk);
    chk("t2_grant_m1", 32'(grant), 32'(2'b10));
    wait_ack(1);
    @(posedge clk); #1;
    drop(1);
    repeat (2) @(posedge clk); #1;

    // 3: both masters streaming -> strict alternation
    glog.delete();
    fork
      run_m(0, 8);
      run_m(1, 12);
    join
    repeat (2) @(posedge clk); #1;
    chk("t3_grant_count", 32'(glog.size()), 32'(8));
    for (int i = 1; i < glog.size(); i++)
      chk($sformatf("t3_alternate_%0d", i), 32'(glog[i] != glog[i-1]), 32'(1));

    // 4: m1 3-beat locked write while m0 waits
    issue(1, 1'b1, 24'h20, 8'h11, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_grant_m1", 32'(grant), 32'(2'b10));
    issue(0, 1'b0, 24'h7, '0, 8'h77);
    wait_ack(1);
    @(posedge clk); #1;
    issue(1, 1'b1, 24'h21, 8'h22, '0);
    wait_ack(1);
    chk("t4_lock_b2", 32'(grant), 32'(2'b10));
    @(posedge clk); #1;
    issue(1, 1'b1, 24'h22, 8'h33, '0);
    wait_ack(1);
    chk("t4_lock_b3", 32'(grant), 32'(2'b10));
    @(posedge clk); #1;
    drop(1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_dead_grant", 32'(grant), 32'(2'b00));
    chk("t4_dead_s_cyc", 32'(s_cyc), 32'(0));
    @(negedge clk);
    chk("t4_grant_m0", 32'(grant), 32'(2'b01));
    wait_ack(0);
    @(posedge clk); #1;
    drop(0);
    repeat (2) @(posedge clk); #1;

    // 5: async reset mid-transaction, then tie goes to m0 again
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 24'h9;
    @(negedge clk);
    @(negedge clk);
    chk("t5_grant_m0", 32'(grant), 32'(2'b01));
    chk("t5_s_stb", 32'(s_stb), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'(0));
    chk("t5_rst_s_bus", 32'({s_cyc, s_stb, s_we, s_adr}), 32'(0));
    chk("t5_rst_acks", 32'({m_ack, m_err, m_rdat[0]}), 32'(0));
    drop(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 24'h5, '0, 8'h55);
    issue(1, 1'b0, 24'h6, '0, 8'h66);
    @(negedge clk);
    @(negedge clk);
    chk("t5_tie_m0", 32'(grant), 32'(2'b01));
    wait_ack(0);
    @(posedge clk); #1;
    drop(0);
    wait_ack(1);
    @(posedge clk); #1;
    drop(1);
    repeat (2) @(posedge clk); #1;

`ifdef WB_ARB_TIMEOUT_EN
    // 6: hung slave -> err after 8 stb cycles, bus freed for m1
    hang = 1'b1;
    q0.push_back('{err: 1'b1, chk: 1'b0, dat: '0});
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 24'hA;
    issue(1, 1'b0, 24'hB, '0, 8'hBB);
    @(negedge clk);
    @(negedge clk);
    chk("t6_grant_m0", 32'(grant), 32'(2'b01));
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t6_no_err_%0d", k), 32'(m_err[0]), 32'(0));
    end
    @(negedge clk);
    chk("t6_err", 32'(m_err[0]), 32'(1));
    @(posedge clk); #1;
    hang = 1'b0;
    drop(0);
    @(negedge clk);
    chk("t6_idle_after_err", 32'(grant), 32'(2'b00));
    chk("t6_err_one_cycle", 32'(m_err[0]), 32'(0));
    wait_ack(1);
    @(posedge clk); #1;
    drop(1);
    repeat (2) @(posedge clk); #1;
`endif

    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));
    chk("swq_drained", 32'(swq.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
